// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU op sequencer: opcodes, condition-code bits,
// execution-condition encodings and FSM states.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_DBL   = 4'd2;
  localparam logic [3:0] OP_HALF  = 4'd3;
  localparam logic [3:0] OP_PASSA = 4'd4;
  localparam logic [3:0] OP_PASSB = 4'd5;
  localparam logic [3:0] OP_MAX   = 4'd6;
  localparam logic [3:0] OP_MIN   = 4'd7;

  localparam int unsigned CC_ARITH = 0;
  localparam int unsigned CC_ZERO  = 1;
  localparam int unsigned CC_AGE   = 2;
  localparam int unsigned CC_BGT   = 3;

  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_ZERO   = 2'b01;
  localparam logic [1:0] COND_AGE    = 2'b10;
  localparam logic [1:0] COND_BGT    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RET  = 2'd2
  } state_t;

  function automatic logic cond_met(input logic [1:0] cond, input logic [3:0] cc);
    logic met;
    unique case (cond)
      COND_ALWAYS: met = 1'b1;
      COND_ZERO:   met = cc[CC_ZERO];
      COND_AGE:    met = cc[CC_AGE];
      COND_BGT:    met = cc[CC_BGT];
      default:     met = 1'b1;
    endcase
    return met;
  endfunction

endpackage

// File: rtl/alu_seq_cmd_fifo.sv
// Synchronous command FIFO for the ALU op sequencer (power-of-two depth,
// asynchronous active-high reset). Full blocks pushes even if a pop coincides.
module alu_seq_cmd_fifo
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-driven sequencer for the CCU ALU: FIFO-buffered reg-to-reg ops,
// register file, IDLE/EXEC/RET FSM. Define ALU_SEQ_COND_EN for conditional execution.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NREGS     = 8,
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned CMD_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_src_a,
  input  logic [ADDR_W-1:0] cmd_src_b,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [1:0]        cmd_cond,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_n,
  input  logic [DATA_W-1:0] alu_r,
  input  logic [3:0]        alu_cc,
  input  logic              alu_we,
  output logic              done,
  output logic              done_err,
  output logic              done_skip,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        cc_q,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

`ifdef ALU_SEQ_COND_EN
  localparam int unsigned ENTRY_W = 4 + 3*ADDR_W + 2;
`else
  localparam int unsigned ENTRY_W = 4 + 3*ADDR_W;
`endif

  logic [ENTRY_W-1:0] entry_in, head;
  logic               fifo_full, fifo_empty, pop;
  logic [3:0]         h_op;
  logic [ADDR_W-1:0]  h_sa, h_sb, h_dst;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  regs_q [NREGS];
  logic [DATA_W-1:0]  regs_d [NREGS];
  logic [DATA_W-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]         alu_n_q, alu_n_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic [3:0]         cc_sav_q, cc_sav_d;
  logic [ADDR_W-1:0]  dst_q, dst_d;
  logic               err_q, err_d;

`ifdef ALU_SEQ_COND_EN
  logic [1:0]         h_cond;
  logic               skip_q, skip_d;
  assign entry_in  = {cmd_op, cmd_src_a, cmd_src_b, cmd_dst, cmd_cond};
  assign h_cond    = head[1:0];
  assign done_skip = done && skip_q;
`else
  logic               unused_cond;
  assign entry_in    = {cmd_op, cmd_src_a, cmd_src_b, cmd_dst};
  assign unused_cond = ^cmd_cond;
  assign done_skip   = 1'b0;
`endif

  // Fields are anchored at the MSB so the optional cond bits sit below them.
  assign h_op  = head[ENTRY_W-1 -: 4];
  assign h_sa  = head[ENTRY_W-5 -: ADDR_W];
  assign h_sb  = head[ENTRY_W-5-ADDR_W -: ADDR_W];
  assign h_dst = head[ENTRY_W-5-2*ADDR_W -: ADDR_W];

  alu_seq_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (cmd_valid),
    .wdata (entry_in),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cmd_ready = !fifo_full;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_n     = alu_n_q;
  assign result    = result_q;
  assign cc_q      = cc_sav_q;
  assign dbg_data  = regs_q[dbg_addr];
  assign done      = (state_q == ST_RET);
  assign done_err  = done && err_q;

  always_comb begin
    state_d  = state_q;
    regs_d   = regs_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_n_d  = alu_n_q;
    result_d = result_q;
    cc_sav_d = cc_sav_q;
    dst_d    = dst_q;
    err_d    = err_q;
`ifdef ALU_SEQ_COND_EN
    skip_d   = skip_q;
`endif
    pop      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop   = 1'b1;
          dst_d = h_dst;
          err_d = 1'b0;
`ifdef ALU_SEQ_COND_EN
          skip_d = 1'b0;
`endif
          if (h_op[3]) begin
            err_d   = 1'b1;
            state_d = ST_RET;
          end
`ifdef ALU_SEQ_COND_EN
          else if (!cond_met(h_cond, cc_sav_q)) begin
            skip_d  = 1'b1;
            state_d = ST_RET;
          end
`endif
          else begin
            alu_a_d = regs_q[h_sa];
            alu_b_d = regs_q[h_sb];
            alu_n_d = h_op;
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        result_d = alu_r;
        cc_sav_d = alu_cc;
        if (alu_we) begin
          regs_d[dst_q] = alu_r;
        end
        state_d = ST_RET;
      end
      ST_RET: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_n_q  <= OP_PASSA;
      result_q <= '0;
      cc_sav_q <= '0;
      dst_q    <= '0;
      err_q    <= 1'b0;
`ifdef ALU_SEQ_COND_EN
      skip_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      regs_q   <= regs_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_n_q  <= alu_n_d;
      result_q <= result_d;
      cc_sav_q <= cc_sav_d;
      dst_q    <= dst_d;
      err_q    <= err_d;
`ifdef ALU_SEQ_COND_EN
      skip_q   <= skip_d;
`endif
    end
  end

endmodule
